// File: rtl/rf2p_mbank_pkg.sv
// rf2p_mbank_pkg
// Shared configuration for the masked multi-lane two-port register file:
//   - con_rw_e   : result returned by a read that hits the address being
//                  written in the same cycle (OLD / NEW / UNDEF)
//   - RLAT_MAX   : deepest supported read pipeline
//   - rlat_legal : elaboration-time legality check for the read latency
package rf2p_mbank_pkg;

  typedef enum logic [1:0] {
    OLD   = 2'd0,
    NEW   = 2'd1,
    UNDEF = 2'd2
  } con_rw_e;

  localparam int RLAT_MAX = 2;

  function automatic bit rlat_legal(input int rlat);
    return (rlat >= 1) && (rlat <= RLAT_MAX);
  endfunction

endpackage

// File: rtl/rf2p_mbank_lane.sv
// rf2p_lane
// One lane of the register file: storage array, masked write, registered
// read and the same-address collision mux.
// Ports:
//   i_clk, i_rst_n      clock / async active-low reset (read register only)
//   i_read, i_raddr     read request and address
//   i_write, i_waddr    write request and address
//   i_wen               this lane's write-mask bit
//   i_wdata             this lane's write word
//   i_collide           shared same-address read/write detect from the top
//   o_rdata             registered read word (holds when no read)
module rf2p_lane
  import rf2p_mbank_pkg::*;
#(
  parameter int      DWD    = 16,
  parameter int      AWD    = 5,
  parameter con_rw_e CON_RW = OLD
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_read,
  input  logic [AWD-1:0] i_raddr,
  input  logic           i_write,
  input  logic [AWD-1:0] i_waddr,
  input  logic           i_wen,
  input  logic [DWD-1:0] i_wdata,
  input  logic           i_collide,
  output logic [DWD-1:0] o_rdata
);

  localparam int DEPTH = 1 << AWD;

  logic [DWD-1:0] mem_q [DEPTH];
  logic [DWD-1:0] rdata_q, rdata_d;

  // Storage is deliberately not reset; only this lane's mask bit gates it.
  always_ff @(posedge i_clk) begin
    if (i_write && i_wen) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  // The array read sees pre-write contents (the write lands at the same
  // edge), so OLD falls out naturally; NEW and UNDEF only override lanes
  // whose mask bit is set during a collision.
  always_comb begin
    rdata_d = rdata_q;
    if (i_read) begin
      rdata_d = mem_q[i_raddr];
      if (i_collide && i_wen) begin
        case (CON_RW)
          NEW:     rdata_d = i_wdata;
          UNDEF:   rdata_d = 'x;
          default: rdata_d = mem_q[i_raddr];
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/rf2p_mbank.sv
// rf2p_mbank
// Behavioural model of a masked multi-lane two-port register file: NBANK
// lanes of DWD-bit words sharing one read and one write address.
// Ports:
//   i_clk, i_rst_n      clock / async active-low reset (pipeline state only)
//   i_read, i_raddr     read request and shared read address
//   o_rdata             per-lane read data, valid when o_rvalid
//   o_rvalid            one-cycle strobe per read, RLAT cycles after request
//   i_write, i_waddr    write request and shared write address
//   i_wmsk              per-lane write enable
//   i_wdata             per-lane write data
//   o_collide           read hit the write address in its request cycle
module rf2p_mbank
  import rf2p_mbank_pkg::*;
#(
  parameter int      NBANK  = 4,
  parameter int      DWD    = 16,
  parameter int      AWD    = 5,
  parameter int      RLAT   = 1,
  parameter con_rw_e CON_RW = OLD
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_read,
  input  logic [AWD-1:0]             i_raddr,
  output logic [NBANK-1:0][DWD-1:0]  o_rdata,
  output logic                       o_rvalid,
  input  logic                       i_write,
  input  logic [AWD-1:0]             i_waddr,
  input  logic [NBANK-1:0]           i_wmsk,
  input  logic [NBANK-1:0][DWD-1:0]  i_wdata,
  output logic                       o_collide
);

  if (!rlat_legal(RLAT)) begin : g_rlat_err
    $error("RFCfg::ErrorRF: RLAT=%0d is not supported (1..%0d)", RLAT, RLAT_MAX);
  end

  logic                      collide;
  logic                      valid1_q, collide1_q;
  logic [NBANK-1:0][DWD-1:0] lane_rdata;

  // Collision is independent of the mask: an all-zero-mask write to the
  // read address still flags it.
  assign collide = i_read && i_write && (i_raddr == i_waddr);

  for (genvar k = 0; k < NBANK; k++) begin : g_lane
    rf2p_lane #(
      .DWD    (DWD),
      .AWD    (AWD),
      .CON_RW (CON_RW)
    ) u_lane (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_read    (i_read),
      .i_raddr   (i_raddr),
      .i_write   (i_write),
      .i_waddr   (i_waddr),
      .i_wen     (i_wmsk[k]),
      .i_wdata   (i_wdata[k]),
      .i_collide (collide),
      .o_rdata   (lane_rdata[k])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid1_q   <= 1'b0;
      collide1_q <= 1'b0;
    end else begin
      valid1_q   <= i_read;
      collide1_q <= collide;
    end
  end

  if (RLAT == 2) begin : g_out_stage
    logic                      valid2_q, collide2_q;
    logic [NBANK-1:0][DWD-1:0] rdata2_q, rdata2_d;

    // Output register only reloads on a valid first stage so o_rdata holds
    // between reads, matching the single-stage behaviour one cycle later.
    always_comb begin
      rdata2_d = rdata2_q;
      if (valid1_q) begin
        rdata2_d = lane_rdata;
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        valid2_q   <= 1'b0;
        collide2_q <= 1'b0;
        rdata2_q   <= '0;
      end else begin
        valid2_q   <= valid1_q;
        collide2_q <= collide1_q;
        rdata2_q   <= rdata2_d;
      end
    end

    assign o_rvalid  = valid2_q;
    assign o_collide = collide2_q;
    assign o_rdata   = rdata2_q;
  end else begin : g_no_out_stage
    assign o_rvalid  = valid1_q;
    assign o_collide = collide1_q;
    assign o_rdata   = lane_rdata;
  end

endmodule

// File: doc/rf2p_mbank.md
# rf2p_mbank

Parametrised behavioural two-port register-file array: NBANK lanes of DWD-bit words sharing one read address and one write address, with per-lane write mask. Configurable read latency and read/write collision semantics. Successor to the single-lane RF2P wrappers; sits behind the PE-array buffers as the SIM/FPGA model of masked multi-lane RF macros, and exposes the shared-control RF2P port set plus `o_rvalid` and `o_collide`.

## Interface
- NBANK, 4: number of lanes sharing control
- DWD, 16: lane data width
- AWD, 5: address width; depth = 2**AWD words per lane
- RLAT, 1: read latency in cycles, legal values 1 or 2
- CON_RW, SramCfg::OLD: same-address read/write result: OLD, NEW or UNDEF
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_read  in  1  read request
- i_raddr  in  AWD  read address
- o_rdata  out  [NBANK][DWD]  read data, valid when o_rvalid
- o_rvalid  out  1  read data valid strobe
- i_write  in  1  write request
- i_waddr  in  AWD  write address
- i_wmsk  in  NBANK  per-lane write enable, 1 = lane written
- i_wdata  in  [NBANK][DWD]  write data
- o_collide  out  1  same-address read/write in the same cycle, aligned with o_rvalid

## Operation
- Write: i_write=1 at edge → lanes with i_wmsk[k]=1 store i_wdata[k] at i_waddr; other lanes untouched. i_write with i_wmsk=0 is a no-op.
- Read: i_read=1 at edge samples all lanes at i_raddr. Data appears RLAT cycles later with o_rvalid=1 for exactly one cycle per request; back-to-back reads every cycle are supported, full throughput.
- No read: o_rvalid=0, o_rdata holds last value.
- Collision = i_read & i_write & (i_raddr==i_waddr) in the same cycle:
  - OLD: all lanes return pre-write contents.
  - NEW: lanes with i_wmsk[k]=1 return i_wdata[k] (bypass); unmasked lanes return stored data.
  - UNDEF: masked lanes return all-X; unmasked lanes return stored data.
  - o_collide=1 alongside that read's o_rvalid in all modes; 0 otherwise.
- Writes never alter data already sampled into the read pipeline (RLAT=2).
- Storage array not reset; contents undefined until written. Reset clears only pipeline/valid state.
- Illegal RLAT → elaboration-time RFCfg::ErrorRF.

## Timing
- Reset (asynchronous, i_rst_n=0): o_rvalid=0, o_collide=0, o_rdata=0, pipeline stages cleared; in-flight reads discarded, never produce o_rvalid after reset release.
- RLAT=1: read sampled at edge N → o_rdata/o_rvalid valid after edge N (cycle N+1).
- RLAT=2: extra output register; valid in cycle N+2. Collision resolution is decided at edge N, then pipelined.
- Write at edge N visible to a non-colliding read sampled at edge N+1.
- Address wrap: addresses are modulo 2**AWD; no out-of-range case.

## Structure
- Package RFCfg: add `RLAT_MAX=2` and the legality check; reuse SramCfg::ConcurrentRW for CON_RW, SramCfg::GEN_MODE selects this behavioural model.
- Package holds a typedef for the lane word (logic [DWD-1:0]) via parametrised struct-free packed arrays in ports.
- Sub-module `rf2p_lane`: one lane's storage, masked write, raw registered read and collision bypass mux; instantiated NBANK times in a generate loop. Top owns shared collide detect, rvalid/collide pipeline and optional output stage.

## Test plan
- Reset then write all lanes addr 3 = {0x1111,0x2222,0x3333,0x4444}, read addr 3 → o_rdata equals written words, o_rvalid one cycle at latency RLAT (1 and 2 configs).
- Masked write i_wmsk=4'b0101 data 0xAAAA to addr 3 over previous → read returns {0xAAAA,0x2222,0xAAAA,0x4444}.
- Collision addr 7 holding 0x0005, write 0x00FF mask 4'b0001 → OLD: lane0=0x0005; NEW: lane0=0x00FF; UNDEF: lane0=X; lanes1-3 stored value; o_collide=1.
- Continuous reads addr 0..31 every cycle, wrap to 0 → 32 consecutive o_rvalid pulses, data in order, no gaps.
- Assert i_rst_n=0 mid-flight with RLAT=2 after two read requests → o_rvalid/o_rdata/o_collide immediately 0, no valid after release.
- Same cycle read addr 4 and write addr 5 → no collide, read returns old addr-4 data, subsequent read addr 5 returns new data.
